clock_phase_monitor: RTL and testbench
======================================

Name: clock_phase_monitor

Overview:
- Receive-side checker and decoder for the master-clock enable set: en_q, en_e, en_q_n, en_e_n, en_6m and en_4m.
- Recovers the 12-state phase index from the strobes and verifies every strobe lands on its slot.
- Declares lock after a run of clean E cycles and reconstructs the CPU Q and E clock levels for downstream bus logic.
- Sits beside the clock generator at the top level, feeding the bus sequencer and the debug registers.

Parameters:
- LOCK_CYCLES, 4, number of consecutive clean 12-clock cycles required before locked asserts (range 1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  master clock (12 clocks per E cycle)
- rst  in  1  reset, synchronous, active-high
- en_q  in  1  Q-rise strobe
- en_e  in  1  E-rise strobe
- en_q_n  in  1  Q-fall strobe
- en_e_n  in  1  E-fall strobe
- en_6m  in  1  6 MHz enable
- en_4m  in  1  4 MHz enable
- err_clr  in  1  synchronous clear of err_count
- locked  out  1  phase alignment verified
- phase  out  4  recovered phase index 0..11 (0 = en_q slot); 0 when not locked
- q_level  out  1  reconstructed Q clock; 0 when not locked
- e_level  out  1  reconstructed E clock; 0 when not locked
- err  out  1  one-clock pulse on a detected violation
- err_count  out  ERR_W  saturating violation count

Behaviour:
- Strobe vector: S = {en_6m, en_4m, en_e_n, en_q_n, en_e, en_q}.
- Expected S per phase:
  - 0 = 010001
  - 1 = 100000
  - 2 = 000000
  - 3 = 110010
  - 4 = 000000
  - 5 = 100000
  - 6 = 010100
  - 7 = 100000
  - 8 = 000000
  - 9 = 111000
  - 10 = 000000
  - 11 = 100000
- Reset: state=HUNT, ph_cnt=0, good_cnt=0, and all outputs 0 (locked, phase, q_level, e_level, err, err_count).
- FSM states: HUNT, VERIFY, LOCKED.
  - ph_cnt advances mod 12 every clock in VERIFY/LOCKED. Input sampled in a clock is compared against the mask for (ph_cnt+1) mod 12.
  - HUNT: S == 010001 -> ph_cnt=0, good_cnt=0, go VERIFY. Any other S, including en_q with wrong companions, stays in HUNT with no err.
  - VERIFY: mismatch -> err pulse, go HUNT. A match at phase 11 increments good_cnt. When the incremented value equals LOCK_CYCLES -> go LOCKED.
  - LOCKED: mismatch -> err pulse, go HUNT. locked, phase and levels drop to 0 on the same edge.
  - A mismatching en_q never re-acquires in the same clock. Re-acquisition waits for the next clean phase-0 vector.
- Output timing:
  - locked rises on the edge that registers the final clean phase-11 sample.
  - phase is registered and equals ph_cnt while LOCKED.
- Level reconstruction, registered, updated only in VERIFY/LOCKED and forced 0 elsewhere; gated by locked at the output:
  - q_level: set by en_q, cleared by en_q_n.
  - e_level: set by en_e, cleared by en_e_n.
- err_count:
  - Increments on each err pulse and saturates at all-ones.
  - err_clr has priority over a simultaneous err and yields 0.
  - rst mid-operation returns everything to reset values on the next edge.

Optional Feature:
- Macro: CLOCK_PHASE_MONITOR_CAPTURE_EN.
- When defined, adds outputs cap_valid (1), cap_phase (4) and cap_vec (6). The first violation after reset or err_clr latches the expected phase and the offending S. Later violations do not overwrite them. err_clr clears all three.
- When undefined, these ports and registers are absent.

Decomposition:
- Shared package clock_pkg holds:
  - PHASES=12.
  - Strobe-vector bit-index constants.
  - The 12-entry expected-mask constant array.
  - The monitor state enum.
- One natural sub-module: phase_mask_rom, a combinational phase -> expected-S lookup that the bench can reuse as its reference model.

Test Plan:
- Clean generator stream after reset, LOCK_CYCLES=4 -> locked rises 48 clocks after the first phase-0 vector. phase cycles 0..11. q_level high for phases 0..5, e_level high for phases 3..8. err_count=0.
- Drop one en_e_n at phase 9 while locked -> err pulses once, locked=0 next edge, err_count=1. Relock 48 clocks after the next phase-0 vector.
- en_q presented with en_4m=0 in HUNT -> stays in HUNT, err=0, err_count unchanged.
- Inject 260 violations with ERR_W=8 -> err_count holds at 255. err_clr together with an err in the same clock -> err_count=0.
- Assert rst at phase 5 while locked -> all outputs 0 on the next edge. Relock 48 clocks after the next clean phase-0 vector.
- With CLOCK_PHASE_MONITOR_CAPTURE_EN, an extra en_6m at phase 2 followed by a dropped en_q -> cap_valid=1, cap_phase=2, cap_vec=100000, unchanged by the second error.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the master-clock enable monitor.
//   PHASES            : E-cycle length in master clocks
//   S_*               : bit positions inside the strobe vector
//                       S = {en_6m, en_4m, en_e_n, en_q_n, en_e, en_q}
//   MASK              : expected strobe vector for each phase (index 0 = en_q slot)
//   mon_state_t       : monitor FSM states
//   next_phase()      : modulo-PHASES increment
package clock_pkg;

  localparam int unsigned PHASES = 12;
  localparam int unsigned S_W    = 6;

  localparam int unsigned S_Q    = 0;
  localparam int unsigned S_E    = 1;
  localparam int unsigned S_Q_N  = 2;
  localparam int unsigned S_E_N  = 3;
  localparam int unsigned S_4M   = 4;
  localparam int unsigned S_6M   = 5;

  typedef logic [S_W-1:0] strobe_t;

  localparam strobe_t MASK [PHASES] = '{
    6'b010001, 6'b100000, 6'b000000, 6'b110010,
    6'b000000, 6'b100000, 6'b010100, 6'b100000,
    6'b000000, 6'b111000, 6'b000000, 6'b100000
  };

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } mon_state_t;

  function automatic logic [3:0] next_phase(input logic [3:0] p);
    return (p == 4'(PHASES - 1)) ? 4'd0 : p + 4'd1;
  endfunction

endpackage

// File: rtl/clock_phase_monitor_phase_mask_rom.sv
// phase_mask_rom: combinational phase -> expected strobe vector lookup.
//   phase in  4 : phase index 0..11
//   mask  out 6 : expected {en_6m, en_4m, en_e_n, en_q_n, en_e, en_q};
//                 all zeros for out-of-range indices
module phase_mask_rom
  import clock_pkg::*;
(
  input  logic [3:0] phase,
  output logic [5:0] mask
);

  always_comb begin
    mask = '0;
    if (phase < 4'(PHASES)) mask = MASK[phase];
  end

endmodule

// File: rtl/clock_phase_monitor.sv
// clock_phase_monitor: receive-side checker/decoder for the master-clock
// enable set. Recovers the 12-state phase index, flags any strobe that
// misses its slot, declares lock after LOCK_CYCLES clean E cycles and
// rebuilds the Q/E clock levels.
//   clk, rst (sync, active-high)
//   en_q, en_e, en_q_n, en_e_n, en_6m, en_4m : strobes under test
//   err_clr   : synchronous clear of err_count (and capture regs)
//   locked    : phase alignment verified
//   phase     : recovered phase 0..11, 0 when not locked
//   q_level   : reconstructed Q clock, 0 when not locked
//   e_level   : reconstructed E clock, 0 when not locked
//   err       : one-clock pulse per violation
//   err_count : saturating violation count
// Optional macro CLOCK_PHASE_MONITOR_CAPTURE_EN adds cap_valid, cap_phase,
// cap_vec: expected phase and offending vector of the first violation.
module clock_phase_monitor
  import clock_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_q,
  input  logic             en_e,
  input  logic             en_q_n,
  input  logic             en_e_n,
  input  logic             en_6m,
  input  logic             en_4m,
  input  logic             err_clr,
  output logic             locked,
  output logic [3:0]       phase,
  output logic             q_level,
  output logic             e_level,
  output logic             err,
  output logic [ERR_W-1:0] err_count
`ifdef CLOCK_PHASE_MONITOR_CAPTURE_EN
  ,
  output logic             cap_valid,
  output logic [3:0]       cap_phase,
  output logic [5:0]       cap_vec
`endif
);

  logic [5:0] s;
  logic [5:0] exp_s;
  logic [3:0] ph_cnt, nxt_ph, ph_n;
  logic [3:0] good_cnt, good_n;
  logic       q_lvl, e_lvl, q_n, e_n;
  logic       viol;
  mon_state_t state, st_n;

  assign s      = {en_6m, en_4m, en_e_n, en_q_n, en_e, en_q};
  assign nxt_ph = next_phase(ph_cnt);

  // The sample taken this clock belongs to the slot after ph_cnt.
  phase_mask_rom u_rom (
    .phase (nxt_ph),
    .mask  (exp_s)
  );

  always_comb begin
    st_n   = state;
    ph_n   = ph_cnt;
    good_n = good_cnt;
    q_n    = q_lvl;
    e_n    = e_lvl;
    viol   = 1'b0;
    case (state)
      HUNT: begin
        q_n = 1'b0;
        e_n = 1'b0;
        if (s == MASK[0]) begin
          st_n   = VERIFY;
          ph_n   = '0;
          good_n = '0;
        end
      end
      default: begin
        if (s != exp_s) begin
          // No same-clock re-acquire: even a valid phase-0 vector here is a fault.
          viol   = 1'b1;
          st_n   = HUNT;
          ph_n   = '0;
          good_n = '0;
          q_n    = 1'b0;
          e_n    = 1'b0;
        end else begin
          ph_n = nxt_ph;
          if (s[S_Q])   q_n = 1'b1;
          if (s[S_Q_N]) q_n = 1'b0;
          if (s[S_E])   e_n = 1'b1;
          if (s[S_E_N]) e_n = 1'b0;
          if (state == VERIFY && nxt_ph == 4'(PHASES - 1)) begin
            good_n = good_cnt + 4'd1;
            if (good_n == 4'(LOCK_CYCLES)) st_n = LOCKED;
          end
        end
      end
    endcase
  end

  // Outputs are registered from next-state values so locked, phase and
  // levels change on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      ph_cnt    <= '0;
      good_cnt  <= '0;
      q_lvl     <= 1'b0;
      e_lvl     <= 1'b0;
      locked    <= 1'b0;
      phase     <= '0;
      q_level   <= 1'b0;
      e_level   <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state    <= st_n;
      ph_cnt   <= ph_n;
      good_cnt <= good_n;
      q_lvl    <= q_n;
      e_lvl    <= e_n;
      locked   <= (st_n == LOCKED);
      phase    <= (st_n == LOCKED) ? ph_n : 4'd0;
      q_level  <= (st_n == LOCKED) & q_n;
      e_level  <= (st_n == LOCKED) & e_n;
      err      <= viol;
      if (err_clr)                      err_count <= '0;
      else if (viol && err_count != '1) err_count <= err_count + 1'b1;
    end
  end

`ifdef CLOCK_PHASE_MONITOR_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      cap_valid <= 1'b0;
      cap_phase <= '0;
      cap_vec   <= '0;
    end else if (viol && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_phase <= nxt_ph;
      cap_vec   <= s;
    end
  end
`endif

endmodule

// File: tb/tb_clock_phase_monitor.sv
module tb_clock_phase_monitor;

  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       rst, en_q, en_e, en_q_n, en_e_n, en_6m, en_4m, err_clr;
  logic       locked, q_level, e_level, err;
  logic [3:0] phase;
  logic [7:0] err_count;
`ifdef CLOCK_PHASE_MONITOR_CAPTURE_EN
  logic       cap_valid;
  logic [3:0] cap_phase;
  logic [5:0] cap_vec;
`endif

  always #5 clk = ~clk;

  clock_phase_monitor #(.LOCK_CYCLES(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .en_q(en_q), .en_e(en_e), .en_q_n(en_q_n),
    .en_e_n(en_e_n), .en_6m(en_6m), .en_4m(en_4m), .err_clr(err_clr),
    .locked(locked), .phase(phase), .q_level(q_level), .e_level(e_level),
    .err(err), .err_count(err_count)
`ifdef CLOCK_PHASE_MONITOR_CAPTURE_EN
    , .cap_valid(cap_valid), .cap_phase(cap_phase), .cap_vec(cap_vec)
`endif
  );

  // Generator pattern {en_6m, en_4m, en_e_n, en_q_n, en_e, en_q}
  logic [5:0] gen_tbl [12] = '{
    6'b010001, 6'b100000, 6'b000000, 6'b110010,
    6'b000000, 6'b100000, 6'b010100, 6'b100000,
    6'b000000, 6'b111000, 6'b000000, 6'b100000
  };

  typedef struct {
    logic       locked;
    logic [3:0] phase;
    logic       q;
    logic       e;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int gen_ph = 0;
  int step_no = 0;

  // behavioural model state: 0 hunt, 1 verify, 2 locked
  int m_st = 0, m_ph = 0, m_good = 0, m_cnt = 0;
  bit m_q = 0, m_e = 0;

  task automatic step(input logic [5:0] sv, input logic clr, input logic r);
    exp_t x;
    int nx;
    bit viol;
    {en_6m, en_4m, en_e_n, en_q_n, en_e, en_q} = sv;
    err_clr = clr;
    rst = r;
    viol = 0;
    if (r) begin
      m_st = 0; m_ph = 0; m_good = 0; m_cnt = 0; m_q = 0; m_e = 0;
    end else begin
      nx = (m_ph + 1) % 12;
      if (m_st == 0) begin
        m_q = 0; m_e = 0;
        if (sv == gen_tbl[0]) begin m_st = 1; m_ph = 0; m_good = 0; end
      end else if (sv != gen_tbl[nx]) begin
        viol = 1; m_st = 0; m_ph = 0; m_good = 0; m_q = 0; m_e = 0;
      end else begin
        m_ph = nx;
        if (sv[0]) m_q = 1;
        if (sv[2]) m_q = 0;
        if (sv[1]) m_e = 1;
        if (sv[3]) m_e = 0;
        if (m_st == 1 && nx == 11) begin
          m_good++;
          if (m_good == LOCK) m_st = 2;
        end
      end
      if (clr) m_cnt = 0;
      else if (viol && m_cnt < 255) m_cnt++;
    end
    x.locked = (m_st == 2);
    x.phase  = x.locked ? 4'(m_ph) : 4'd0;
    x.q      = x.locked & m_q;
    x.e      = x.locked & m_e;
    x.err    = viol;
    x.cnt    = 8'(m_cnt);
    sbq.push_back(x);
    @(posedge clk);
    #1;
    step_no++;
    x = sbq.pop_front();
    checks++;
    if ({locked, phase, q_level, e_level, err, err_count} !==
        {x.locked, x.phase, x.q, x.e, x.err, x.cnt}) begin
      errors++;
      $display("FAIL scoreboard step %0d: got locked=%b phase=%0d q=%b e=%b err=%b cnt=%0d, expected locked=%b phase=%0d q=%b e=%b err=%b cnt=%0d",
               step_no, locked, phase, q_level, e_level, err, err_count,
               x.locked, x.phase, x.q, x.e, x.err, x.cnt);
    end
  endtask

  task automatic gen1();
    step(gen_tbl[gen_ph], 1'b0, 1'b0);
    gen_ph = (gen_ph + 1) % 12;
  endtask

  // From HUNT with gen_ph==0: locked must rise on the 48th generator clock.
  task automatic run_to_lock(input string tag);
    repeat (47) gen1();
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL %s_early: locked=%b expected 0 after 47 clocks", tag, locked);
    end
    gen1();
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL %s_late: locked=%b expected 1 after 48 clocks", tag, locked);
    end
  endtask

  task automatic test_reset();
    step(6'b000000, 1'b0, 1'b1);
    checks++;
    if ({locked, phase, q_level, e_level, err, err_count} !== 16'h0) begin
      errors++;
      $display("FAIL reset: got locked=%b phase=%0d q=%b e=%b err=%b cnt=%0d, expected all 0",
               locked, phase, q_level, e_level, err, err_count);
    end
  endtask

  task automatic test_hunt_bad_q();
    step(6'b000001, 1'b0, 1'b0);
    step(6'b000000, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b0 || err_count !== 8'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL hunt_bad_q: err=%b cnt=%0d locked=%b, expected 0 0 0", err, err_count, locked);
    end
  endtask

  task automatic test_lock();
    gen_ph = 0;
    run_to_lock("lock");
    for (int i = 0; i < 12; i++) begin
      gen1();
      checks++;
      if (phase !== 4'(i) || q_level !== (i < 6) || e_level !== (i >= 3 && i <= 8)) begin
        errors++;
        $display("FAIL lock_levels: phase=%0d q=%b e=%b, expected phase=%0d q=%b e=%b",
                 phase, q_level, e_level, i, (i < 6), (i >= 3 && i <= 8));
      end
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++; $display("FAIL lock_errcnt: got %0d expected 0", err_count);
    end
  endtask

  task automatic test_drop_e_n();
    repeat (9) gen1();
    step(gen_tbl[9] & ~6'b001000, 1'b0, 1'b0);
    gen_ph = 10;
    checks++;
    if (err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL drop_e_n: err=%b locked=%b cnt=%0d, expected 1 0 1", err, locked, err_count);
    end
    gen1();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_pulse_width: err=%b expected 0", err);
    end
    gen1();
    run_to_lock("relock_err");
  endtask

  task automatic test_rst_mid();
    repeat (6) gen1();
    checks++;
    if (phase !== 4'd5) begin
      errors++; $display("FAIL rst_mid_phase: phase=%0d expected 5", phase);
    end
    step(gen_tbl[6], 1'b0, 1'b1);
    gen_ph = 7;
    checks++;
    if ({locked, phase, q_level, e_level, err, err_count} !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid: got locked=%b phase=%0d q=%b e=%b err=%b cnt=%0d, expected all 0",
               locked, phase, q_level, e_level, err, err_count);
    end
    while (gen_ph != 0) gen1();
    run_to_lock("relock_rst");
  endtask

  task automatic test_saturate();
    step(6'b000000, 1'b0, 1'b0);
    repeat (259) begin
      step(gen_tbl[0], 1'b0, 1'b0);
      step(6'b000000, 1'b0, 1'b0);
    end
    checks++;
    if (err_count !== 8'd255 || err !== 1'b1) begin
      errors++; $display("FAIL saturate: cnt=%0d err=%b, expected 255 1", err_count, err);
    end
    step(gen_tbl[0], 1'b0, 1'b0);
    step(6'b000000, 1'b1, 1'b0);
    checks++;
    if (err_count !== 8'd0 || err !== 1'b1) begin
      errors++; $display("FAIL clr_priority: cnt=%0d err=%b, expected 0 1", err_count, err);
    end
  endtask

`ifdef CLOCK_PHASE_MONITOR_CAPTURE_EN
  task automatic test_capture();
    step(6'b000000, 1'b0, 1'b1);
    checks++;
    if (cap_valid !== 1'b0) begin
      errors++; $display("FAIL cap_reset: cap_valid=%b expected 0", cap_valid);
    end
    step(gen_tbl[0], 1'b0, 1'b0);
    step(gen_tbl[1], 1'b0, 1'b0);
    step(6'b100000, 1'b0, 1'b0);
    checks++;
    if (cap_valid !== 1'b1 || cap_phase !== 4'd2 || cap_vec !== 6'b100000) begin
      errors++;
      $display("FAIL cap_first: valid=%b phase=%0d vec=%b, expected 1 2 100000", cap_valid, cap_phase, cap_vec);
    end
    gen_ph = 0;
    repeat (12) gen1();
    step(gen_tbl[0] & ~6'b000001, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || cap_valid !== 1'b1 || cap_phase !== 4'd2 || cap_vec !== 6'b100000) begin
      errors++;
      $display("FAIL cap_hold: err=%b valid=%b phase=%0d vec=%b, expected 1 1 2 100000", err, cap_valid, cap_phase, cap_vec);
    end
    step(6'b000000, 1'b1, 1'b0);
    checks++;
    if (cap_valid !== 1'b0 || cap_phase !== 4'd0 || cap_vec !== 6'd0) begin
      errors++;
      $display("FAIL cap_clr: valid=%b phase=%0d vec=%b, expected 0 0 000000", cap_valid, cap_phase, cap_vec);
    end
  endtask
`endif

  initial begin
    {rst, en_q, en_e, en_q_n, en_e_n, en_6m, en_4m, err_clr} = '0;
    test_reset();
    test_hunt_bad_q();
    test_lock();
    test_drop_e_n();
    test_rst_mid();
    test_saturate();
`ifdef CLOCK_PHASE_MONITOR_CAPTURE_EN
    test_capture();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
